// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl
//   Arbitrates capture-side writes and readback-side reads onto one
//   bidirectional SRAM data bus. All pad-facing controls are registered and
//   sequenced so the FPGA output driver and the SRAM output driver are never
//   enabled in the same or in adjacent cycles. Reads are tagged with a valid
//   shift register so data coming back through the input sampling flops is
//   presented with rd_valid.
//
//   Optional build macro: SRAM_RR_ARB_EN
//     defined   -> ties go to the requester not granted most recently
//     undefined -> fixed write priority (capture never stalls)
//
// Parameters
//   AW      SRAM address width
//   DW      SRAM data width
//   RD_LAT  cycles from read bus cycle to data on sram_din (1..7)
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data    write request (held until wr_ack)
//   wr_ack                    combinational accept pulse for a write
//   rd_req/rd_addr            read request (held until rd_ack)
//   rd_ack                    combinational accept pulse for a read
//   rd_valid/rd_data          returned read data, in issue order
//   sram_addr/sram_dout       registered address / write data to pads
//   sram_drive                registered output-pad enable (1 = FPGA drives)
//   sram_ce_n/we_n/oe_n       registered active-low strobes
//   sram_din                  bus value after the input sampling flops
module sram_bus_ctrl #(
  parameter int AW     = 18,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  output logic          sram_drive,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  input  logic [DW-1:0] sram_din
);

  localparam int            TCW     = 3;
  localparam logic [TCW-1:0] TC_LOAD = TCW'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

  state_t         state, state_nx;
  logic [TCW-1:0] tc, tc_nx;
  logic           wr_pref;
  logic           pick_wr;
  logic           pick_rd;
  logic [RD_LAT:0] rd_vld_sr;

`ifdef SRAM_RR_ARB_EN
  // 1 = the most recent grant went to the write side. Resets to "read" so
  // the first tie is handed to the write side.
  logic last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_grant <= 1'b0;
    else if (wr_ack) last_grant <= 1'b1;
    else if (rd_ack) last_grant <= 1'b0;
  end

  assign wr_pref = ~last_grant;
`else
  assign wr_pref = 1'b1;
`endif

  // Arbitration winner among the current requests; whether it can be
  // acknowledged this cycle depends on the bus state below.
  assign pick_wr = wr_req & (~rd_req | wr_pref);
  assign pick_rd = rd_req & ~pick_wr;

  // Next state and Mealy acks. The next state is WR/RD exactly when the
  // matching ack fires, so the registered pad controls below follow the ack.
  always_comb begin
    state_nx = state;
    tc_nx    = tc;
    wr_ack   = 1'b0;
    rd_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_wr) begin
          wr_ack   = 1'b1;
          state_nx = WR;
        end else if (pick_rd) begin
          rd_ack   = 1'b1;
          state_nx = RD;
        end
      end
      WR: begin
        if (pick_wr) begin
          wr_ack   = 1'b1;
          state_nx = WR;
        end else if (pick_rd) begin
          // one released-bus cycle before the first read bus cycle
          state_nx = TURN;
          tc_nx    = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      RD: begin
        if (pick_rd) begin
          rd_ack   = 1'b1;
          state_nx = RD;
        end else begin
          // Even with no pending write the bus must drain: the SRAM may
          // still be driving returned data for RD_LAT cycles.
          state_nx = TURN;
          tc_nx    = TC_LOAD;
        end
      end
      TURN: begin
        if (pick_rd) begin
          rd_ack   = 1'b1;
          state_nx = RD;
          tc_nx    = '0;
        end else if (pick_wr && tc == '0) begin
          wr_ack   = 1'b1;
          state_nx = WR;
        end else if (tc == '0) begin
          state_nx = IDLE;
        end else begin
          tc_nx = tc - TCW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        tc_nx    = '0;
      end
    endcase
    // no accept pulses while reset is asserted
    if (!reset_n) begin
      wr_ack = 1'b0;
      rd_ack = 1'b0;
    end
  end

  // Registered pad controls, state and read-valid tagging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tc         <= '0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_drive <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      rd_vld_sr  <= '0;
    end else begin
      state      <= state_nx;
      tc         <= tc_nx;
      sram_ce_n  <= ~(wr_ack | rd_ack);
      sram_we_n  <= ~wr_ack;
      sram_oe_n  <= ~rd_ack;
      sram_drive <= wr_ack;
      if (wr_ack) begin
        sram_addr <= wr_addr;
        sram_dout <= wr_data;
      end else if (rd_ack) begin
        sram_addr <= rd_addr;
      end
      // bit 0 marks the read bus cycle; bit RD_LAT is the data-return cycle
      rd_vld_sr <= {rd_vld_sr[RD_LAT-1:0], rd_ack};
    end
  end

  assign rd_valid = rd_vld_sr[RD_LAT];
  assign rd_data  = sram_din;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
`timescale 1ns/1ps
module tb_sram_bus_ctrl;
  parameter int RD_LAT = 2;
  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          sram_drive;
  logic          sram_ce_n;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic [DW-1:0] sram_din;

  sram_bus_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_drive(sram_drive),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_din(sram_din)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM model: unwritten words read as 0xC0000000 | addr
  logic [DW-1:0] mem [int];
  logic [DW-1:0] dly [0:7];
  logic          s_oe_n = 1'b1;
  logic          s_we_n = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_dout = '0;
  int            cyc = 0;

  always @(negedge clk) begin
    s_oe_n = sram_oe_n;
    s_we_n = sram_we_n;
    s_addr = sram_addr;
    s_dout = sram_dout;
  end

  always @(posedge clk) begin
    cyc++;
    if (!s_we_n) mem[int'(s_addr)] = s_dout;
    for (int k = 7; k > 0; k--) dly[k] = dly[k-1];
    if (!s_oe_n)
      dly[0] = mem.exists(int'(s_addr)) ? mem[int'(s_addr)] : (32'hC000_0000 | 32'(s_addr));
    else
      dly[0] = 32'hDEAD_BEEF;
    sram_din = dly[RD_LAT-1];
  end

  // Bus monitor: returned data log and contention / gap violations
  int            v_cyc [$];
  logic [DW-1:0] v_dat [$];
  int            viol = 0;
  int            gap_viol = 0;
  int            last_rd_cyc = -100;
  logic          p_drive = 1'b0;
  logic          p_oe = 1'b0;

  always @(negedge clk) begin
    if (rd_valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(rd_data);
    end
    if (sram_drive && !sram_oe_n) viol++;
    if ((p_drive && !sram_oe_n) || (p_oe && sram_drive)) viol++;
    p_drive = sram_drive;
    p_oe    = !sram_oe_n;
    if (!sram_oe_n) last_rd_cyc = cyc;
    if (sram_drive && (cyc - last_rd_cyc) < RD_LAT + 1) gap_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int w;
    int nw;
    int nr;
    int g [$];

    // ---- reset state, write request already pending ----
    wr_req  = 1'b1;
    wr_addr = 18'h00010;
    wr_data = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_drive", sram_drive, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dout", sram_dout, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);

    // ---- first write after reset: no penalty ----
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("wr1_ack", wr_ack, 1);
    chk("wr1_rd_ack", rd_ack, 0);
    @(posedge clk); #1 wr_req = 1'b0;
    @(negedge clk);
    chk("wr1_we_n", sram_we_n, 0);
    chk("wr1_ce_n", sram_ce_n, 0);
    chk("wr1_oe_n", sram_oe_n, 1);
    chk("wr1_drive", sram_drive, 1);
    chk("wr1_addr", sram_addr, 18'h00010);
    chk("wr1_dout", sram_dout, 32'hA5A5A5A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr1_end_we_n", sram_we_n, 1);
    chk("wr1_end_drive", sram_drive, 0);

    // ---- write then read: exactly one TURN cycle ----
    @(posedge clk); #1 wr_req = 1'b1;
    @(negedge clk);
    chk("war_wr_ack", wr_ack, 1);
    @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b1; rd_addr = 18'h00010;
    @(negedge clk);
    chk("war_no_rd_ack_in_wr", rd_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("war_turn_rd_ack", rd_ack, 1);
    chk("war_turn_drive", sram_drive, 0);
    chk("war_turn_oe_n", sram_oe_n, 1);
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    chk("war_rd_oe_n", sram_oe_n, 0);
    chk("war_rd_addr", sram_addr, 18'h00010);
    for (int k = 1; k <= RD_LAT; k++) begin
      chk("war_rdv_early", rd_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("war_rdv", rd_valid, 1);
    chk("war_rd_data", rd_data, 32'hA5A5A5A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("war_rdv_single", rd_valid, 0);
    repeat (RD_LAT + 3) @(posedge clk);
    #1;

    // ---- 8 back-to-back reads then a write ----
    base = v_cyc.size();
    for (int i = 0; i < 8; i++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(i);
      @(negedge clk);
      chk("burst_rd_ack", rd_ack, 1);
      @(posedge clk); #1;
    end
    rd_req  = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 18'h00020;
    wr_data = 32'h5A5A0000;
    w = 0;
    @(negedge clk);
    while (!wr_ack && w < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    chk("burst_wr_latency_ok", (w >= RD_LAT && w < 40), 1);
    @(posedge clk); #1 wr_req = 1'b0;
    repeat (RD_LAT + 4) @(posedge clk);
    #1;
    chk("burst_valid_count", v_cyc.size() - base, 8);
    if (v_cyc.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("burst_rd_data", v_dat[base+i], 32'hC000_0000 | 32'(i));
        chk("burst_rd_consec", v_cyc[base+i] - v_cyc[base], i);
      end
    end

    // ---- simultaneous requests held for 20 cycles ----
    nw = 0;
    nr = 0;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    wr_addr = 18'h00030;
    wr_data = 32'h1234_5678;
    rd_addr = 18'h00031;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ack) begin nw++; g.push_back(1); end
      if (rd_ack) begin nr++; g.push_back(0); end
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
`ifndef SRAM_RR_ARB_EN
    chk("tie_wr_acks", nw, 20);
    chk("tie_rd_acks", nr, 0);
`else
    chk("rr_rd_acks_ge2", (nr >= 2), 1);
    chk("rr_first_is_wr", (g.size() > 0) ? g[0] : 0, 1);
    for (int i = 1; i < g.size(); i++)
      chk("rr_alternate", g[i], !g[i-1]);
`endif
    repeat (RD_LAT + 4) @(posedge clk);
    #1;

    // ---- reset in the middle of a read burst ----
    for (int i = 0; i < 2; i++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(i);
      @(negedge clk);
      chk("rstb_rd_ack", rd_ack, 1);
      @(posedge clk); #1;
    end
    #1;
    chk("rstb_pre_oe_n", sram_oe_n, 0);
    base = v_cyc.size();
    reset_n = 1'b0;
    #1;
    chk("rstb_async_oe_n", sram_oe_n, 1);
    chk("rstb_async_ce_n", sram_ce_n, 1);
    chk("rstb_async_drive", sram_drive, 0);
    chk("rstb_rd_ack_gated", rd_ack, 0);
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (RD_LAT + 6) @(posedge clk);
    @(negedge clk);
    chk("rstb_no_valid", v_cyc.size() - base, 0);
    @(posedge clk); #1 wr_req = 1'b1; wr_addr = 18'h00040;
    @(negedge clk);
    chk("rstb_post_wr_ack", wr_ack, 1);
    @(posedge clk); #1 wr_req = 1'b0;
    repeat (3) @(posedge clk);

    // ---- whole-run bus protocol checks ----
    @(negedge clk);
    chk("bus_contention", viol, 0);
    chk("rd_to_wr_gap", gap_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
